// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA3-256 block padder.
// Build option: define KECCAK_LEGACY_PAD_EN for original Keccak pad10*1 (domain byte 0x01).
package sha3_pkg;

  localparam int unsigned RATE_BYTES = 136;
  localparam int unsigned RATE_LANES = 17;
  localparam int unsigned LANE_W     = 64;

`ifdef KECCAK_LEGACY_PAD_EN
  localparam logic [7:0] PAD_DOMAIN = 8'h01;
`else
  localparam logic [7:0] PAD_DOMAIN = 8'h06;
`endif
  localparam logic [7:0] PAD_END = 8'h80;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HOLD   = 2'd1,
    PADBLK = 2'd2
  } state_e;

endpackage

// File: rtl/sha3_pad_lane.sv
// Masks one lane to its valid bytes and ORs in the domain and/or end padding byte.
module sha3_pad_lane
  import sha3_pkg::*;
(
  input  logic [LANE_W-1:0] lane_in,
  input  logic [3:0]        nb,        // bytes kept, 0..8
  input  logic              pad_here,  // domain byte lands at byte nb of this lane
  input  logic              end_byte,  // this lane carries the final byte of the block
  output logic [LANE_W-1:0] lane_out
);

  // Per-byte keep/pad selection.
  always_comb begin
    lane_out = '0;
    for (int k = 0; k < int'(LANE_W / 8); k++) begin
      if (4'(k) < nb) lane_out[8*k +: 8] = lane_in[8*k +: 8];
      if (pad_here && (4'(k) == nb)) lane_out[8*k +: 8] = lane_out[8*k +: 8] | PAD_DOMAIN;
      if (end_byte && (k == int'(LANE_W / 8) - 1)) begin
        lane_out[8*k +: 8] = lane_out[8*k +: 8] | PAD_END;
      end
    end
  end

endmodule

// File: rtl/sha3_block_padder.sv
// Packs 64-bit message lanes into 1088-bit rate blocks and applies SHA3 padding.
// Build option: KECCAK_LEGACY_PAD_EN selects the Keccak domain byte (see sha3_pkg).
module sha3_block_padder
  import sha3_pkg::*;
#(
  parameter int unsigned RATE_LANES = sha3_pkg::RATE_LANES,
  parameter int unsigned LANE_W     = sha3_pkg::LANE_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANE_W-1:0]            in_data,
  input  logic [3:0]                   in_nbytes,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [RATE_LANES*LANE_W-1:0] block_out,
  output logic                         block_valid,
  output logic                         block_last,
  input  logic                         block_ready
);

  localparam int unsigned   CNT_W    = $clog2(RATE_LANES);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATE_LANES - 1);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [RATE_LANES*LANE_W-1:0] block_q, block_d;
  logic                         last_q, last_d;
  logic                         pend_q, pend_d;
  logic                         armed_q;

  logic [RATE_LANES*LANE_W-1:0] pad_blk;
  logic [3:0]                   n_sat;
  logic [3:0]                   pad_n;
  logic                         accept;
  logic                         boundary;

  assign n_sat    = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;
  // The padding-only block is the same as an empty last lane in slot 0.
  assign pad_n    = (state_q == PADBLK) ? 4'd0 : n_sat;
  assign in_ready = armed_q && (state_q == FILL);
  assign accept   = in_valid && in_ready;
  // Message ends exactly on a block boundary: padding needs a block of its own.
  assign boundary = in_last && (cnt_q == LAST_SLOT) && (n_sat == 4'd8);

  assign block_out   = block_q;
  assign block_valid = (state_q == HOLD);
  assign block_last  = last_q;

  for (genvar l = 0; l < int'(RATE_LANES); l++) begin : g_lane
    logic [3:0]        nb;
    logic              here;
    logic [LANE_W-1:0] src;

    // Lanes below cnt are kept whole, lane cnt is trimmed, lanes above are cleared.
    always_comb begin
      if (cnt_q > CNT_W'(l))       nb = 4'd8;
      else if (cnt_q == CNT_W'(l)) nb = pad_n;
      else                         nb = 4'd0;
      here = ((cnt_q == CNT_W'(l)) && (pad_n != 4'd8)) ||
             ((cnt_q + 1'b1 == CNT_W'(l)) && (pad_n == 4'd8));
      src  = (cnt_q == CNT_W'(l)) ? in_data : block_q[l*LANE_W +: LANE_W];
    end

    sha3_pad_lane u_pad (
      .lane_in  (src),
      .nb       (nb),
      .pad_here (here),
      .end_byte (l == int'(RATE_LANES) - 1),
      .lane_out (pad_blk[l*LANE_W +: LANE_W])
    );
  end

  // Next-state logic: lane writes, block completion and HOLD release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    last_d  = last_q;
    pend_d  = pend_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (in_last && !boundary) begin
            block_d = pad_blk;
            last_d  = 1'b1;
            state_d = HOLD;
          end else begin
            for (int l = 0; l < int'(RATE_LANES); l++) begin
              if (cnt_q == CNT_W'(l)) block_d[l*LANE_W +: LANE_W] = in_data;
            end
            if (cnt_q == LAST_SLOT) begin
              last_d  = 1'b0;
              pend_d  = boundary;
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (block_ready) begin
          block_d = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = pend_q ? PADBLK : FILL;
        end
      end
      PADBLK: begin
        block_d = pad_blk;
        last_d  = 1'b1;
        state_d = HOLD;
      end
      default: state_d = FILL;
    endcase
  end

  // State registers; reset discards any partial or pending block at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      block_q <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      armed_q <= 1'b1;
    end
  end

  // Byte counts above 8 are illegal on the last beat.
  nbytes_legal_a : assert property (@(posedge clk) disable iff (reset)
    (in_valid && in_ready && in_last) |-> (in_nbytes <= 4'd8));

endmodule

// File: tb/tb_sha3_block_padder.sv
// Directed self-checking bench for sha3_block_padder.
module tb_sha3_block_padder;

`ifdef KECCAK_LEGACY_PAD_EN
  localparam logic [7:0] DOM = 8'h01;
`else
  localparam logic [7:0] DOM = 8'h06;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   in_data;
  logic [3:0]    in_nbytes;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [1087:0] block_out;
  logic          block_valid;
  logic          block_last;
  logic          block_ready;

  int checks = 0;
  int errors = 0;

  sha3_block_padder dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_nbytes   (in_nbytes),
    .in_last     (in_last),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_last  (block_last),
    .block_ready (block_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int i);
    return 64'h0101_0101_0101_0101 * 64'(i + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [1087:0] got, input logic [1087:0] exp);
    int bad = 0;
    checks++;
    assert (got === exp) else begin
      errors++;
      for (int l = 16; l >= 0; l--) if (got[64*l +: 64] !== exp[64*l +: 64]) bad = l;
      $error("FAIL %s lane %0d: got %0h expected %0h", tag, bad, got[64*bad +: 64],
             exp[64*bad +: 64]);
    end
  endtask

  // Present one lane and hold it until it is accepted (bounded).
  task automatic send(input logic [63:0] d, input logic [3:0] n, input logic l);
    int w = 0;
    in_data = d; in_nbytes = n; in_last = l; in_valid = 1'b1;
    while (!in_ready && w < 40) begin @(posedge clk); #1; w++; end
    chk("send_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait up to max_wait cycles for a block, check it, then consume it.
  task automatic take(input string tag, input logic [1087:0] exp, input logic exp_last,
                      input int max_wait);
    int w = 0;
    while (!block_valid && w < max_wait) begin @(posedge clk); #1; w++; end
    chk({tag, "_valid"}, {63'd0, block_valid}, 64'd1);
    chk_blk({tag, "_data"}, block_out, exp);
    chk({tag, "_last"}, {63'd0, block_last}, {63'd0, exp_last});
    chk({tag, "_inrdy"}, {63'd0, in_ready}, 64'd0);
    block_ready = 1'b1;
    @(posedge clk); #1;
    block_ready = 1'b0;
    chk({tag, "_drop"}, {63'd0, block_valid}, 64'd0);
  endtask

  logic [1087:0] e_pad, e;

  initial begin
    reset = 1'b1; in_data = '0; in_nbytes = '0; in_last = 1'b0; in_valid = 1'b0;
    block_ready = 1'b0;
    e_pad = '0; e_pad[7:0] = DOM; e_pad[1087:1080] = 8'h80;

    #3;
    chk("rst_valid", {63'd0, block_valid}, 64'd0);
    chk("rst_last", {63'd0, block_last}, 64'd0);
    chk("rst_inrdy", {63'd0, in_ready}, 64'd0);
    chk_blk("rst_block", block_out, '0);
    #9 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_inrdy", {63'd0, in_ready}, 64'd1);

    // Empty message: padding only, latency 1.
    send(64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b1);
    take("empty", e_pad, 1'b1, 0);

    // "abc".
    e = '0; e[63:0] = {32'd0, DOM, 24'h636261}; e[1087:1080] = 8'h80;
    send(64'h0000_0000_0063_6261, 4'd3, 1'b1);
    take("abc", e, 1'b1, 0);

    // Two full lanes, last with n=8: domain byte opens lane 2.
    e = '0; e[63:0] = 64'hA1A2_A3A4_A5A6_A7A8; e[127:64] = 64'hB1B2_B3B4_B5B6_B7B8;
    e[135:128] = DOM; e[1087:1080] = 8'h80;
    send(64'hA1A2_A3A4_A5A6_A7A8, 4'd8, 1'b0);
    send(64'hB1B2_B3B4_B5B6_B7B8, 4'd8, 1'b1);
    take("two_lane", e, 1'b1, 0);

    // 136-byte message: data block then padding-only block.
    e = '0;
    for (int i = 0; i < 17; i++) e[64*i +: 64] = pat(i);
    for (int i = 0; i < 16; i++) send(pat(i), 4'd8, 1'b0);
    send(pat(16), 4'd8, 1'b1);
    take("b136_data", e, 1'b0, 0);
    take("b136_pad", e_pad, 1'b1, 3);

    // 135-byte message: domain and end bytes share byte 135.
    e[1087:1024] = {8'h80 | DOM, 56'h11_1111_1111_1111};
    for (int i = 0; i < 16; i++) send(pat(i), 4'd8, 1'b0);
    send(pat(16), 4'd7, 1'b1);
    take("b135", e, 1'b1, 0);

    // Back-pressure: block stays put and no lane is taken while held.
    send(64'h0, 4'd0, 1'b1);
    in_data = 64'h1122_3344_5566_7788; in_nbytes = 4'd2; in_last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk_blk("hold_block", block_out, e_pad);
      chk("hold_inrdy", {63'd0, in_ready}, 64'd0);
    end
    chk("hold_valid", {63'd0, block_valid}, 64'd1);
    block_ready = 1'b1;
    @(posedge clk); #1;
    block_ready = 1'b0;
    chk("hold_rel_inrdy", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = '0; e[63:0] = {40'd0, DOM, 16'h7788}; e[1087:1080] = 8'h80;
    take("after_hold", e, 1'b1, 0);

    // Reset after 5 lanes discards the partial block immediately.
    for (int i = 0; i < 5; i++) send(pat(i), 4'd8, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_valid", {63'd0, block_valid}, 64'd0);
    chk("midrst_inrdy", {63'd0, in_ready}, 64'd0);
    chk_blk("midrst_block", block_out, '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    send(64'h0, 4'd0, 1'b1);
    take("midrst_empty", e_pad, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
